dmem_store_buffer: RTL
======================

DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; power of two, minimum 2.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Parameter DATA_W, default 32, store/load data width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 core_we  in  1  core store request this cycle.
REQ-007 core_addr  in  ADDR_W  store byte address.
REQ-008 core_wdata  in  DATA_W  store data.
REQ-009 core_fetch_addr  in  ADDR_W  load byte address.
REQ-010 core_rdata  out  DATA_W  load data, forwarded or from DMEM.
REQ-011 core_stall  out  1  store not accepted this cycle; core holds request.
REQ-012 mem_ready  in  1  DMEM write port accepts a write this cycle.
REQ-013 mem_we  out  1  DMEM write strobe.
REQ-014 mem_addr  out  ADDR_W  DMEM write address.
REQ-015 mem_wdata  out  DATA_W  DMEM write data.
REQ-016 mem_fetch_addr  out  ADDR_W  DMEM read address, equal to core_fetch_addr combinationally.
REQ-017 mem_rdata  in  DATA_W  DMEM read data, combinational from mem_fetch_addr.
REQ-018 empty  out  1  no pending stores (registered).

Function
REQ-019 Buffer SHALL be a circular FIFO of DEPTH entries {addr, data} with head and tail pointers and a count of width log2(DEPTH)+1.
REQ-020 Push: core_we && !core_stall SHALL write {core_addr, core_wdata} at tail; tail wraps DEPTH-1 -> 0.
REQ-021 Pop: mem_we && mem_ready SHALL advance head with the same wrap rule.
REQ-022 mem_we SHALL equal !empty; mem_addr/mem_wdata SHALL be the head entry, held stable until popped.
REQ-023 core_stall SHALL be core_we && count==DEPTH && !mem_ready (push accepted while full if a pop occurs the same cycle).
REQ-024 Simultaneous push and pop SHALL leave count unchanged; push into empty buffer SHALL NOT reach mem_we before the next cycle (minimum store-to-DMEM latency 1 cycle).
REQ-025 Forwarding: word address core_fetch_addr[ADDR_W-1:2] SHALL be compared against every valid entry; on any match core_rdata SHALL be the data of the youngest matching entry, else mem_rdata.
REQ-026 The store being pushed in the current cycle SHALL NOT be forwarded; forwarding SHALL include the head entry even when it is popped that cycle.
REQ-027 Addresses SHALL be compared at word granularity only; bits [1:0] ignored.
REQ-028 Count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-029 Assertion of reset (low) SHALL immediately clear head, tail and count; mem_we=0, empty=1, core_stall=0; pending stores are discarded.
REQ-030 Entry storage SHALL NOT require reset; invalid entries never forward.
REQ-031 Reset mid-drain SHALL drop mem_we in the same cycle, without waiting for a clock edge.

Structure
REQ-032 DEPTH, ADDR_W and DATA_W defaults and the entry record type SHALL live in the shared package strontium_pkg.
REQ-033 Youngest-match priority search SHALL be the single sub-module sb_forward_match (inputs: entry addresses, valid mask, head pointer, lookup address; outputs: hit, index).
REQ-034 Block SHALL sit between Core DMEM port and DMEM, with no other glue.

Verification
REQ-035 Store 0x100<-0xAAAA5555 with mem_ready=1 -> next cycle mem_we=1, mem_addr=0x100, mem_wdata=0xAAAA5555; following cycle empty=1.
REQ-036 mem_ready=0, four stores to 0x0,0x4,0x8,0xC, fifth store -> core_stall=1 on fifth; raise mem_ready -> fifth accepted that cycle, count stays 4.
REQ-037 mem_ready=0, stores 0x40<-1 then 0x40<-2, load 0x42 -> core_rdata=2; load 0x44 -> core_rdata=mem_rdata.
REQ-038 Push and pop every cycle for 3*DEPTH stores -> pointers wrap, DMEM receives all stores in order, no stall.
REQ-039 Three stores pending, reset low between edges -> mem_we=0 and empty=1 immediately; after release, no old store appears.
REQ-040 Store 0x80<-7 and load 0x80 in same cycle, buffer empty -> core_rdata=mem_rdata (no same-cycle forward).

Source files
------------

// File: rtl/strontium_pkg.sv
// Shared defaults and the buffered-store record for the DMEM store buffer.
package strontium_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    // One pending store. Fields are sized to the package defaults; instances
    // may use narrower ADDR_W/DATA_W, and the top casts values into and out of this record.
    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/dmem_store_buffer_if.sv
// Core-side and DMEM-side bus of the store buffer.
// The slave modport is the buffer; the master modport is the core/DMEM environment.
interface dmem_store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [ADDR_W-1:0] core_fetch_addr;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_fetch_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              empty;

    modport slave (
        input  core_we, core_addr, core_wdata, core_fetch_addr, mem_ready, mem_rdata,
        output core_rdata, core_stall, mem_we, mem_addr, mem_wdata, mem_fetch_addr, empty
    );

    modport master (
        output core_we, core_addr, core_wdata, core_fetch_addr, mem_ready, mem_rdata,
        input  core_rdata, core_stall, mem_we, mem_addr, mem_wdata, mem_fetch_addr, empty
    );
endinterface

// File: rtl/sb_forward_match.sv
// Youngest-match search over the store buffer for load forwarding.
// Slots are walked from oldest (head) to youngest, so the last hit wins.
module sb_forward_match #(
    parameter int  DEPTH = 4,
    parameter int  WA_W  = 30,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WA_W-1:0] entry_addr_i,
    input  logic [DEPTH-1:0]           valid_i,
    input  logic [PTR_W-1:0]           head_i,
    input  logic [WA_W-1:0]            lookup_addr_i,
    output logic                       hit_o,
    output logic [PTR_W-1:0]           idx_o
);

    logic [PTR_W-1:0] slot;

    // Age-ordered scan; a younger matching entry overrides an older one.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        slot  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + PTR_W'(k);
            if (valid_i[slot] && (entry_addr_i[slot] == lookup_addr_i)) begin
                hit_o = 1'b1;
                idx_o = slot;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between the core DMEM port and DMEM: circular FIFO of pending
// stores drained one per accepted DMEM write, with word-granular load forwarding.
module dmem_store_buffer
    import strontium_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input logic              clk,
    input logic              reset,
    dmem_store_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - 2;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;

    sb_entry_t entry_q [DEPTH];

    logic                       push, pop, stall;
    logic [PTR_W-1:0]           age;
    logic [DEPTH-1:0]           valid;
    logic [DEPTH-1:0][WA_W-1:0] entry_wa;
    logic                       fwd_hit;
    logic [PTR_W-1:0]           fwd_idx;

    // A full buffer still takes a store when the head drains in the same cycle.
    assign stall = bus.core_we && (count_q == CNT_W'(DEPTH)) && !bus.mem_ready;
    assign push  = bus.core_we && !stall;
    assign pop   = !empty_q && bus.mem_ready;

    // Pointer and occupancy next-state; power-of-two depth makes wrap implicit.
    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        empty_d = (count_d == '0);
    end

    // Control state; reset discards every pending store at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= empty_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[tail_q] <= '{addr: SB_ADDR_W'(bus.core_addr),
                                 data: SB_DATA_W'(bus.core_wdata)};
        end
    end

    // Valid mask from distance to head, plus word addresses for the match.
    always_comb begin
        age      = '0;
        valid    = '0;
        entry_wa = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age         = PTR_W'(i) - head_q;
            valid[i]    = ({1'b0, age} < count_q);
            entry_wa[i] = entry_q[i].addr[ADDR_W-1:2];
        end
    end

    sb_forward_match #(
        .DEPTH (DEPTH),
        .WA_W  (WA_W)
    ) u_match (
        .entry_addr_i  (entry_wa),
        .valid_i       (valid),
        .head_i        (head_q),
        .lookup_addr_i (bus.core_fetch_addr[ADDR_W-1:2]),
        .hit_o         (fwd_hit),
        .idx_o         (fwd_idx)
    );

    assign bus.core_stall     = stall;
    assign bus.empty          = empty_q;
    assign bus.mem_we         = !empty_q;
    assign bus.mem_addr       = ADDR_W'(entry_q[head_q].addr);
    assign bus.mem_wdata      = DATA_W'(entry_q[head_q].data);
    assign bus.mem_fetch_addr = bus.core_fetch_addr;
    assign bus.core_rdata     = fwd_hit ? DATA_W'(entry_q[fwd_idx].data) : bus.mem_rdata;

endmodule
